// File: rtl/mips_pkg.sv
// mips_pkg
//   Definitions shared by the MIPS32 pipeline stages:
//   - access-size encodings carried with loads and stores (ex_size)
//   - memory/write-back stage state encoding
//   - register-zero constant
//   - small helpers for store lane placement and the alignment rule, so
//     that any other load/store path applies exactly the same rules.
package mips_pkg;

  // ex_size[1:0] selects the access width, ex_size[2] marks an unsigned load.
  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam int         SZ_UNSIGNED = 2;

  // Writes to $zero are architecturally discarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } mem_wb_state_t;

  // A halfword must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (width)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Byte enables for a store, little-endian lane numbering.
  function automatic logic [3:0] store_be(input logic [1:0] width,
                                          input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b1111;
    case (width)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across all lanes so the memory only has to
  // honour the byte enables; no shifting is needed on the memory side.
  function automatic logic [31:0] store_wdata(input logic [1:0]  width,
                                              input logic [31:0] data);
    logic [31:0] wd;
    wd = data;
    case (width)
      SZ_BYTE: wd = {4{data[7:0]}};
      SZ_HALF: wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align
//   Combinational load-data extractor. Picks the addressed byte or
//   halfword out of a 32-bit memory word and sign- or zero-extends it.
//   Ports:
//     rdata  in  32  word returned by memory
//     addr   in  2   low address bits of the access
//     size   in  3   access size (bit 2 = unsigned)
//     data   out 32  extended load value
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi +: 8];
  end

  assign is_unsigned = size[SZ_UNSIGNED];
  assign byte_sel    = lane[addr];
  // Halfword lanes are selected by addr[1]; addr[0] is zero for any
  // access that reaches memory.
  assign half_sel    = addr[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  always_comb begin
    data = rdata;
    case (size[1:0])
      SZ_BYTE: data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      SZ_HALF: data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory-access and write-back stage of the MIPS32 pipeline. Takes one
//   executed instruction at a time, performs its load/store on the data
//   memory port and drives the register-file write port for one cycle per
//   retiring register-writing instruction.
//   Ports:
//     clk, rst                    clock, asynchronous active-high reset
//     ex_valid / ex_ready         handshake with the execute stage
//     ex_alu_result               ALU result or effective address
//     ex_store_data               store data (rt)
//     ex_dest, ex_reg_write       destination register and write flag
//     ex_mem_read, ex_mem_write   load / store
//     ex_size                     access size, bit 2 = unsigned load
//     dmem_*                      request/ack data-memory port
//     RegWrite, write_add,
//     write_data                  register-file write port
//     addr_exc                    one-cycle misaligned-access pulse
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [31:0]   ex_alu_result,
  input  logic [DW-1:0] ex_store_data,
  input  logic [4:0]    ex_dest,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic [2:0]    ex_size,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          RegWrite,
  output logic [4:0]    write_add,
  output logic [DW-1:0] write_data,
  output logic          addr_exc
);

  mem_wb_state_t state_reg;

  // Details of the outstanding memory access, needed when the ack returns.
  logic       pend_load_reg;
  logic       pend_reg_write_reg;
  logic [4:0] pend_dest_reg;
  logic [2:0] pend_size_reg;
  logic [1:0] pend_lane_reg;

  logic        is_mem;
  logic        misaligned;
  logic [31:0] load_value;

  assign ex_ready   = (state_reg == ST_IDLE);
  assign is_mem     = ex_mem_read | ex_mem_write;
  assign misaligned = is_misaligned(ex_size[1:0], ex_alu_result[1:0]);

  load_align u_load_align (
    .rdata (dmem_rdata),
    .addr  (pend_lane_reg),
    .size  (pend_size_reg),
    .data  (load_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      dmem_req           <= 1'b0;
      dmem_we            <= 1'b0;
      dmem_addr          <= '0;
      dmem_be            <= 4'b0000;
      dmem_wdata         <= '0;
      RegWrite           <= 1'b0;
      write_add          <= 5'd0;
      write_data         <= '0;
      addr_exc           <= 1'b0;
      pend_load_reg      <= 1'b0;
      pend_reg_write_reg <= 1'b0;
      pend_dest_reg      <= 5'd0;
      pend_size_reg      <= 3'b000;
      pend_lane_reg      <= 2'b00;
    end else begin
      // Both strobes last exactly one cycle unless re-armed below.
      RegWrite <= 1'b0;
      addr_exc <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              // Register result retires in the very next cycle. The write
              // port fields follow the instruction even for $zero; only
              // the strobe is suppressed.
              RegWrite   <= ex_reg_write && (ex_dest != REG_ZERO);
              write_add  <= ex_dest;
              write_data <= ex_alu_result;
            end else if (misaligned) begin
              // Dropped: no memory traffic, no write-back.
              addr_exc <= 1'b1;
            end else begin
              state_reg          <= ST_WAIT_ACK;
              dmem_req           <= 1'b1;
              dmem_we            <= ex_mem_write;
              dmem_addr          <= {ex_alu_result[AW-1:2], 2'b00};
              dmem_be            <= ex_mem_write
                                    ? store_be(ex_size[1:0], ex_alu_result[1:0])
                                    : 4'b1111;
              dmem_wdata         <= ex_mem_write
                                    ? store_wdata(ex_size[1:0], ex_store_data)
                                    : '0;
              pend_load_reg      <= ex_mem_read;
              pend_reg_write_reg <= ex_reg_write;
              pend_dest_reg      <= ex_dest;
              pend_size_reg      <= ex_size;
              pend_lane_reg      <= ex_alu_result[1:0];
            end
          end
        end

        ST_WAIT_ACK: begin
          if (dmem_ack) begin
            state_reg <= ST_IDLE;
            dmem_req  <= 1'b0;
            if (pend_load_reg) begin
              // rdata is only valid alongside ack, so it is captured here.
              RegWrite   <= pend_reg_write_reg && (pend_dest_reg != REG_ZERO);
              write_add  <= pend_dest_reg;
              write_data <= load_value;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
